// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues word reads for the current PC, tags responses with their PC,
// and buffers {pc, instr} pairs for decode with credit-based flow control and flush support.
module instr_fetch #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_i,
  output logic        stall_o,
  input  logic        flush_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = CW + 1;

  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] disc_q, disc_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [AW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [AW-1:0] ins_wr_q, ins_wr_d, ins_rd_q, ins_rd_d;
  logic [31:0]   tag_mem_q [DEPTH];
  logic [31:0]   ins_pc_q  [DEPTH];
  logic [31:0]   ins_dat_q [DEPTH];

  logic pop, fire, rsp, keep;
  logic [SW-1:0] credit_used;

  // Pop counts toward credit in the same cycle so DEPTH=2 sustains one fetch per cycle.
  always_comb begin
    pop         = instr_valid_o & instr_ready_i;
    credit_used = SW'(out_q) + SW'(occ_q) - SW'(pop);
    imem_req_o  = !rst_i && !flush_i && (credit_used < SW'(DEPTH));
    imem_addr_o = pc_i;
    fire        = imem_req_o & imem_gnt_i;
    stall_o     = rst_i | (!fire & !flush_i);
    // A response with nothing outstanding is a protocol error and is ignored.
    rsp         = imem_rvalid_i && (out_q != '0);
    keep        = rsp && (disc_q == '0) && !flush_i;
  end

  always_comb begin
    out_d    = out_q + CW'(fire) - CW'(rsp);
    tag_wr_d = tag_wr_q + AW'(fire);
    tag_rd_d = tag_rd_q + AW'(rsp);
    disc_d   = disc_q;
    occ_d    = occ_q + CW'(keep) - CW'(pop);
    ins_wr_d = ins_wr_q + AW'(keep);
    ins_rd_d = ins_rd_q + AW'(pop);
    if (flush_i) begin
      // Every response still owed after this cycle must be dropped.
      disc_d   = out_q - CW'(rsp);
      occ_d    = '0;
      ins_wr_d = '0;
      ins_rd_d = '0;
    end else if (rsp && (disc_q != '0)) begin
      disc_d = disc_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q    <= '0;
      disc_q   <= '0;
      occ_q    <= '0;
      tag_wr_q <= '0;
      tag_rd_q <= '0;
      ins_wr_q <= '0;
      ins_rd_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        tag_mem_q[i] <= '0;
        ins_pc_q[i]  <= '0;
        ins_dat_q[i] <= '0;
      end
    end else begin
      out_q    <= out_d;
      disc_q   <= disc_d;
      occ_q    <= occ_d;
      tag_wr_q <= tag_wr_d;
      tag_rd_q <= tag_rd_d;
      ins_wr_q <= ins_wr_d;
      ins_rd_q <= ins_rd_d;
      if (fire) tag_mem_q[tag_wr_q] <= pc_i;
      if (keep) begin
        ins_pc_q[ins_wr_q]  <= tag_mem_q[tag_rd_q];
        ins_dat_q[ins_wr_q] <= imem_rdata_i;
      end
    end
  end

  assign instr_valid_o = (occ_q != '0);
  assign instr_o       = ins_dat_q[ins_rd_q];
  assign instr_pc_o    = ins_pc_q[ins_rd_q];

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: transaction-level memory and delivery model with
// per-cycle checks of request, stall, address and the decode-side output stream.
module tb_instr_fetch;
  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst, flush, gnt, rvalid, ready;
  logic [31:0] pc_in, rdata;
  logic        stall, req, ivalid;
  logic [31:0] addr, instr, ipc;

  always #5 clk = ~clk;

  instr_fetch #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .pc_i(pc_in), .stall_o(stall), .flush_i(flush),
    .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .instr_valid_o(ivalid), .instr_o(instr), .instr_pc_o(ipc), .instr_ready_i(ready)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          live;
  } mreq_t;

  mreq_t       mq[$];   // granted reads still owed by memory, in order
  logic [31:0] fq[$];   // PCs the decode stage should see, in order
  logic [31:0] pc;
  logic [31:0] tgt;
  int          cyc;
  bit          was_rst;
  int          n_chk = 0;
  int          n_bad = 0;
  int          gnt_pct, rdy_pct, flush_pct, rst_pct, lat_max;

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit pct(input int p);
    return int'($urandom_range(99, 0)) < p;
  endfunction

  task automatic drive(input bit force_rst);
    rst    = force_rst || pct(rst_pct);
    flush  = !rst && pct(flush_pct);
    gnt    = pct(gnt_pct);
    ready  = pct(rdy_pct);
    tgt    = $urandom & 32'hFFFF_FFFC;
    rvalid = !rst && (mq.size() > 0) && (mq[0].due <= cyc);
    rdata  = rvalid ? mdata(mq[0].addr) : $urandom;
    if (rst) pc = $urandom & 32'h0000_FFFC;
    pc_in  = pc;
  endtask

  task automatic cycle(input bit force_rst);
    bit    pop_m, exp_req, fire;
    int    k, due;
    mreq_t e;
    drive(force_rst);
    assert (!rvalid || mq.size() > 0);
    @(negedge clk);
    pop_m = (fq.size() > 0) && ready;
    check32("valid", 32'(ivalid), 32'(fq.size() > 0));
    if (fq.size() > 0) begin
      check32("instr_pc", ipc, fq[0]);
      check32("instr", instr, mdata(fq[0]));
    end
    if (was_rst) begin
      check32("rst_instr", instr, 32'h0);
      check32("rst_instr_pc", ipc, 32'h0);
    end
    exp_req = !rst && !flush && ((mq.size() + fq.size() - int'(pop_m)) < int'(DEPTH));
    check32("req", 32'(req), 32'(exp_req));
    check32("addr", addr, pc);
    fire = exp_req && gnt;
    check32("stall", 32'(stall), 32'(rst || (!fire && !flush)));
    @(posedge clk);
    if (rst) begin
      mq.delete();
      fq.delete();
      was_rst = 1'b1;
    end else begin
      was_rst = 1'b0;
      e = '{addr: 32'h0, due: 0, live: 1'b0};
      if (rvalid) e = mq.pop_front();
      if (flush) begin
        fq.delete();
        foreach (mq[i]) mq[i].live = 1'b0;
      end else begin
        if (pop_m) void'(fq.pop_front());
        if (rvalid && e.live) fq.push_back(e.addr);
      end
      if (fire) begin
        k   = int'($urandom_range(lat_max, 1));
        due = cyc + k;
        if (mq.size() > 0 && mq[$].due > due) due = mq[$].due;
        mq.push_back('{addr: pc, due: due, live: 1'b1});
      end
      if (flush) pc = tgt;
      else if (fire) pc = pc + 32'd4;
    end
    cyc++;
    #1;
  endtask

  task automatic set_knobs(input int g, input int r, input int f, input int rs, input int l);
    gnt_pct = g; rdy_pct = r; flush_pct = f; rst_pct = rs; lat_max = l;
  endtask

  initial begin
    cyc = 0;
    was_rst = 1'b0;
    pc = 32'h0;
    set_knobs(100, 100, 0, 0, 1);
    // Streaming from 0x0 with single-cycle memory and decode always ready.
    for (int i = 0; i < 3; i++) cycle(1'b1);
    pc = 32'h0;
    for (int i = 0; i < 60; i++) cycle(1'b0);
    // Decode back-pressure.
    set_knobs(100, 30, 0, 0, 1);
    for (int i = 0; i < 300; i++) cycle(1'b0);
    // Grant withheld often, longer memory latency.
    set_knobs(40, 80, 0, 0, 3);
    for (int i = 0; i < 300; i++) cycle(1'b0);
    // Redirects against late responses.
    set_knobs(80, 70, 12, 0, 3);
    for (int i = 0; i < 500; i++) cycle(1'b0);
    // Everything random, including mid-operation reset.
    set_knobs(60, 60, 8, 3, 4);
    for (int i = 0; i < 800; i++) cycle(1'b0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage directly downstream of the program counter. Takes the current PC, issues word reads on the instruction-memory request/grant/response port, and tags each returned word with its PC. Buffers results in a small FIFO for the decode stage. Drives the program counter's stall input, so the PC advances only when a fetch is accepted, and supports a single-cycle flush for redirects.

## Interface
Parameters:
- DEPTH, 2, total in-flight plus buffered fetches (credit limit); power of two, ≥2

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- pc_i  in  32  current PC from program counter
- stall_o  out  1  to program counter stall input; low = PC advances to next_pc this cycle
- flush_i  in  1  redirect: discard all in-flight and buffered fetches
- imem_req_o  out  1  read request valid
- imem_addr_o  out  32  read word address (= pc_i)
- imem_gnt_i  in  1  request accepted this cycle (fire = req & gnt)
- imem_rvalid_i  in  1  read data valid; responses are in order, at least 1 cycle after grant
- imem_rdata_i  in  32  read data
- instr_valid_o  out  1  instr_o/instr_pc_o valid
- instr_o  out  32  fetched instruction
- instr_pc_o  out  32  PC of instr_o
- instr_ready_i  in  1  decode accepts head entry (pop = valid & ready)

## Operation
- State:
  - outstanding counter, 0..DEPTH
  - PC tag FIFO (DEPTH entries) holding addresses of granted requests
  - instruction FIFO (DEPTH entries of {pc, instr})
  - discard counter, 0..DEPTH
- Credit rule: imem_req_o = !rst_i && !flush_i && (outstanding + occupancy − pop) < DEPTH.
- imem_addr_o = pc_i. On fire: push pc_i into the tag FIFO and increment outstanding.
- stall_o = !fire && !flush_i. In a flush cycle stall_o is low so the PC loads the redirect target. stall_o is 1 during reset.
- Response handling, on imem_rvalid_i:
  - Pop the tag FIFO and decrement outstanding.
  - If discard > 0: drop the data and decrement discard.
  - Otherwise: push {tag, imem_rdata_i} into the instruction FIFO.
- Fire and rvalid in the same cycle: outstanding is unchanged.
- The instruction FIFO head drives instr_valid_o, instr_o and instr_pc_o (registered; no bypass from imem_rdata_i).
- Flush (flush_i = 1):
  - Instruction FIFO is cleared and no request is issued.
  - discard <= outstanding − (rvalid this cycle and discard = 0 ? 1 : 0) + discard adjustment, i.e. every response still owed after this cycle is dropped.
  - A response arriving in the flush cycle is itself dropped.
  - Tag FIFO entries are still popped by the dropped responses.
- Overflow is impossible by the credit rule. rvalid with outstanding = 0 is a protocol error: ignore it, and the bench asserts it never happens.
- Reset mid-operation clears all counters and FIFOs. Late responses after reset are the memory's responsibility; the memory is reset together with this block.

## Timing
- Reset values: imem_req_o 0, instr_valid_o 0, stall_o 1, instr_o 0, instr_pc_o 0. Outstanding, discard and occupancy are all 0.
- First request is issued in the first cycle with rst_i low.
- Latency: fire in cycle N, rvalid in N+k (k ≥ 1), instr_valid_o high in N+k+1.
- Throughput: with k = 1, DEPTH = 2 and instr_ready_i held high, one instruction per cycle is sustained. Pop counts toward credit in the same cycle.
- After flush in cycle F: instr_valid_o is 0 in F+1. The first post-flush request is issued in F+1 with the new pc_i.
- imem_req_o depends combinationally on instr_ready_i and flush_i. It must not depend on imem_gnt_i.
- Held request: if gnt is low, req stays high with unchanged addr, because the PC is stalled.

## Test plan
- Reset then 1-cycle memory, ready high, PC increments by 4 from 0x0 → instr_valid_o first high 2 cycles after reset release, then every cycle with instr_pc_o = 0x0, 0x4, 0x8… and matching data.
- Decode ready low for 5 cycles → at most 2 fetches issued; req low with stall_o high once outstanding + occupancy = 2. On ready rising, instructions drain in order with no loss or duplication.
- Grant withheld 3 cycles → stall_o high, addr held constant at 0x10; grant at cycle 4 → single fetch of 0x10.
- 3-cycle memory latency with 2 outstanding (0x20, 0x24), flush at cycle 1 with PC redirected to 0x100 → both late responses dropped, next delivered instr_pc_o = 0x100.
- Flush coincident with rvalid and with a pending pop → response dropped, FIFO empty next cycle, no request in the flush cycle, stall_o low.
- Reset asserted with 2 outstanding and 1 buffered → all outputs at reset values the next cycle, and fetching restarts from the new reset PC.
